// File: rtl/nx_fifo_rd_pkg.sv
// Shared types and helpers for the nx_fifo stream read-side drainer.
package nx_fifo_rd_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } nx_rd_occ_e;

    // Beat counter width: max(1, clog2(frame_len)).
    function automatic int beat_w(input int frame_len);
        return (frame_len <= 2) ? 1 : $clog2(frame_len);
    endfunction

endpackage

// File: rtl/nx_fifo_rd_skid.sv
// Two-entry head/tail skid buffer with push/pop/flush; head is the stream output.
module nx_fifo_rd_skid
    import nx_fifo_rd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_din,
    output nx_rd_occ_e        o_occ,
    output logic [DATA_W-1:0] o_head
);

    nx_rd_occ_e        r_occ;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;

    // Occupancy state machine; push is never asserted by the top while full.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (i_push) begin
                        r_occ  <= OCC_ONE;
                        r_head <= i_din;
                    end
                end
                OCC_ONE: begin
                    if (i_push && !i_pop) begin
                        r_occ  <= OCC_TWO;
                        r_tail <= i_din;
                    end else if (i_push && i_pop) begin
                        r_head <= i_din;
                    end else if (i_pop) begin
                        r_occ  <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (i_pop) begin
                        r_occ  <= OCC_ONE;
                        r_head <= r_tail;
                    end
                end
                default: r_occ <= OCC_EMPTY;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_head;

endmodule

// File: rtl/nx_fifo_stream_rd.sv
// Read-side drainer: pops a show-ahead nx_fifo into a registered valid/ready
// stream with frame marking. Optional statistics under NX_FIFO_RD_STATS_EN.
module nx_fifo_stream_rd
    import nx_fifo_rd_pkg::*;
#(
    parameter int DATA_W    = 8,
`ifdef NX_FIFO_RD_STATS_EN
    parameter int STAT_W    = 16,
`endif
    parameter int FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_ren,
    output logic              fifo_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef NX_FIFO_RD_STATS_EN
    output logic [STAT_W-1:0] stat_beats,
    output logic [STAT_W-1:0] stat_stalls,
`endif
    output logic              out_last
);

    localparam int            BW   = beat_w(FRAME_LEN);
    localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);

    nx_rd_occ_e        w_occ;
    logic [DATA_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;
    logic [BW-1:0]     r_beat_cnt;

    // Pop only with room in the buffer; out_ready never reaches this gate.
    assign w_push     = en & ~fifo_empty & ~clear & ~rst & (w_occ != OCC_TWO);
    assign w_pop      = out_valid & out_ready;
    assign fifo_ren   = w_push;
    assign fifo_clear = clear;
    assign out_valid  = (w_occ != OCC_EMPTY);
    assign out_data   = w_head;
    assign out_last   = out_valid & (r_beat_cnt == LAST);

    nx_fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (fifo_rdata),
        .o_occ   (w_occ),
        .o_head  (w_head)
    );

    // Beat-in-frame counter, advanced on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= (r_beat_cnt == LAST) ? '0 : r_beat_cnt + 1'b1;
        end
    end

`ifdef NX_FIFO_RD_STATS_EN
    logic [STAT_W-1:0] r_stat_beats;
    logic [STAT_W-1:0] r_stat_stalls;

    // Saturating accepted-beat and stall-cycle counters.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_stat_beats  <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_pop && (r_stat_beats != '1))
                r_stat_beats <= r_stat_beats + 1'b1;
            if (out_valid && !out_ready && (r_stat_stalls != '1))
                r_stat_stalls <= r_stat_stalls + 1'b1;
        end
    end

    assign stat_beats  = r_stat_beats;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule
